// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: shadowed hex/dp/blank/blink/lzs, one digit lit per slot with a dead cycle between slots.
// Latency: outputs registered, one cycle behind scan state; a load shows on the outputs one cycle after the capturing edge.
// Backpressure: none; the scan free-runs and load is accepted on any edge.
module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int DIV       = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  lzs,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW   = $clog2(DIV);
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DIGITS - 1);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0]   BCNT_LAST = BW'(BLINK_DIV - 1);

    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blink_q;
    logic                lzs_q;

    logic [PW-1:0]   pcnt;
    logic [IDXW-1:0] idx;
    logic [BW-1:0]   bcnt;
    logic            phase;

    logic            slot_end;
    logic            frame_end;
    logic [3:0]      nib;
    logic            dp_cur;
    logic            blank_cur;
    logic            blink_cur;
    logic            lz_cur;
    logic            run;
    logic [DIGITS-1:0] sel;
    logic            dark;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
            blink_q <= '0;
            lzs_q   <= 1'b0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp;
            blank_q <= blank;
            blink_q <= blink;
            lzs_q   <= lzs;
        end
    end

    assign slot_end  = (pcnt == PCNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt  <= '0;
            idx   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
        end else begin
            pcnt <= slot_end ? '0 : pcnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (frame_end) begin
                bcnt <= (bcnt == BCNT_LAST) ? '0 : bcnt + 1'b1;
                if (bcnt == BCNT_LAST)
                    phase <= ~phase;
            end
        end
    end

    // Walk from the top digit down so run tracks "every nibble above and including i is zero".
    always_comb begin
        nib       = 4'h0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        blink_cur = 1'b0;
        lz_cur    = 1'b0;
        sel       = '0;
        run       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run & (value_q[4*i +: 4] == 4'h0);
            if (idx == IDXW'(i)) begin
                nib       = value_q[4*i +: 4];
                dp_cur    = dp_q[i];
                blank_cur = blank_q[i];
                blink_cur = blink_q[i];
                lz_cur    = run;
                sel[i]    = 1'b1;
            end
        end
    end

    assign dark = blank_cur | (blink_cur & phase) | (lzs_q & (idx != '0) & lz_cur);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg   <= 7'h7F;
            dp_n  <= 1'b1;
            an_n  <= '1;
            frame <= 1'b0;
        end else begin
            frame <= frame_end;
            if ((pcnt == '0) || dark) begin
                seg  <= 7'h7F;
                dp_n <= 1'b1;
                an_n <= '1;
            end else begin
                seg  <= ~hex7(nib);
                dp_n <= ~dp_cur;
                an_n <= ~sel;
            end
        end
    end

endmodule
